sw_priority_encoder: RTL and testbench

//  Inverse of the board's 4-to-16 switch decoder: encodes a 16-switch bank into a 4-bit index on LED.

---
 rtl/lab_pkg.sv | 23 ++
 rtl/sw_debounce.sv | 58 +++++
 rtl/sw_priority_encoder.sv | 118 +++++++++++
 tb/tb_sw_priority_encoder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab_pkg.sv
// Shared lab definitions: switch-bank width, encoder FSM states and the
// highest-set-bit helper used by the switch priority encoder.
package lab_pkg;

    localparam int unsigned N_SW      = 16;
    localparam int unsigned SW_CODE_W = $clog2(N_SW);

    typedef enum logic {
        IDLE   = 1'b0,
        REPORT = 1'b1
    } enc_state_t;

    // Index of the highest set bit; 0 for an all-zero vector.
    function automatic logic [SW_CODE_W-1:0] msb_index(input logic [N_SW-1:0] v);
        logic [SW_CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(N_SW); i++) begin
            if (v[i]) idx = SW_CODE_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus settle counter for a raw switch bank.
//   clk       system clock
//   rst       synchronous active-high reset
//   sw        raw asynchronous switch inputs
//   sw_prev   last synchronised vector seen (candidate settled value)
//   stable    sw_prev has been unchanged for DB_CYCLES clocks
// DB_CYCLES must be at least 1.
module sw_debounce
    import lab_pkg::*;
#(
    parameter int unsigned N_IN      = N_SW,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] sw,
    output logic [N_IN-1:0] sw_prev,
    output logic            stable
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

    logic [N_IN-1:0]  sync1;
    logic [N_IN-1:0]  sw_s;
    logic [N_IN-1:0]  prev_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    // Restart the count on any change, otherwise count up and saturate.
    always_comb begin
        prev_n = sw_prev;
        cnt_n  = cnt;
        if (sw_s != sw_prev) begin
            prev_n = sw_s;
            cnt_n  = '0;
        end else if (cnt != CNT_W'(DB_CYCLES)) begin
            cnt_n = cnt + 1'b1;
        end
    end

    // stable is registered from the next count so it equals (cnt == DB_CYCLES).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sw_s    <= '0;
            sw_prev <= '0;
            cnt     <= '0;
            stable  <= 1'b0;
        end else begin
            sync1   <= sw;
            sw_s    <= sync1;
            sw_prev <= prev_n;
            cnt     <= cnt_n;
            stable  <= (cnt_n == CNT_W'(DB_CYCLES));
        end
    end

endmodule

// File: rtl/sw_priority_encoder.sv
// Switch-bank priority encoder: debounces SW and registers the index of the
// highest set switch, announcing each new settled vector via evt/ack.
//   clk    system clock
//   rst    synchronous active-high reset
//   SW     raw asynchronous switch inputs
//   ack    consumer acknowledges the pending event
//   LED    index of the highest set bit of the accepted vector
//   valid  accepted vector is non-zero
//   evt    new accepted vector pending, held until ack
//   err    accepted vector has more than one bit set
// Optional feature macro: SW_ONEHOT_CHECK_EN (builds the multi-hot flag;
// otherwise err is constant 0).
module sw_priority_encoder
    import lab_pkg::*;
#(
    parameter int unsigned N_IN      = N_SW,
    parameter int unsigned CODE_W    = SW_CODE_W,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   SW,
    input  logic              ack,
    output logic [CODE_W-1:0] LED,
    output logic              valid,
    output logic              evt,
    output logic              err
);

    logic [N_IN-1:0]   sw_prev;
    logic              stable;
    enc_state_t        state;
    enc_state_t        state_n;
    logic [N_IN-1:0]   sw_acc;
    logic [N_IN-1:0]   acc_n;
    logic [CODE_W-1:0] led_n;
    logic              valid_n;
    logic              evt_n;

    sw_debounce #(
        .N_IN      (N_IN),
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .sw      (SW),
        .sw_prev (sw_prev),
        .stable  (stable)
    );

`ifdef SW_ONEHOT_CHECK_EN
    logic err_n;
    logic multi_hot;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_hot = |(sw_prev & (sw_prev - N_IN'(1)));
`endif

    // Next-state and output-register values; outputs freeze while reporting.
    always_comb begin
        state_n = state;
        acc_n   = sw_acc;
        led_n   = LED;
        valid_n = valid;
        evt_n   = evt;
`ifdef SW_ONEHOT_CHECK_EN
        err_n   = err;
`endif
        case (state)
            IDLE: begin
                if (stable && (sw_prev != sw_acc)) begin
                    acc_n   = sw_prev;
                    led_n   = CODE_W'(msb_index(N_SW'(sw_prev)));
                    valid_n = |sw_prev;
                    evt_n   = 1'b1;
`ifdef SW_ONEHOT_CHECK_EN
                    err_n   = multi_hot;
`endif
                    state_n = REPORT;
                end
            end
            REPORT: begin
                if (ack) begin
                    evt_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sw_acc <= '0;
            LED    <= '0;
            valid  <= 1'b0;
            evt    <= 1'b0;
        end else begin
            state  <= state_n;
            sw_acc <= acc_n;
            LED    <= led_n;
            valid  <= valid_n;
            evt    <= evt_n;
        end
    end

`ifdef SW_ONEHOT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else     err <= err_n;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sw_priority_encoder.sv
// Testbench for sw_priority_encoder: directed scenarios plus a randomized run
// compared cycle by cycle against a sample-history reference model.
module tb_sw_priority_encoder;

    localparam int unsigned N  = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned DB = 4;
    // History depth: the settle window covers samples 2..DB+2 edges back.
    localparam int unsigned HN = DB + 3;

`ifdef SW_ONEHOT_CHECK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ack;
    logic [N-1:0]  SW;
    logic [CW-1:0] LED;
    logic          valid;
    logic          evt;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sw_priority_encoder #(
        .N_IN      (N),
        .CODE_W    (CW),
        .DB_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .SW    (SW),
        .ack   (ack),
        .LED   (LED),
        .valid (valid),
        .evt   (evt),
        .err   (err)
    );

    // ---------------- reference model ----------------
    logic [N:0]    hist [HN];
    logic          m_busy;
    logic [N-1:0]  m_acc;
    logic [CW-1:0] m_led;
    logic          m_valid;
    logic          m_evt;
    logic          m_err;

    // Highest set bit via log2 arithmetic.
    function automatic logic [CW-1:0] ref_msb(input logic [N-1:0] v);
        int b;
        if (v == '0) return '0;
        b = $clog2({1'b0, v} + 17'd1) - 1;
        return CW'(b);
    endfunction

    function automatic logic ref_err(input logic [N-1:0] v);
        return ERR_ON && ($countones(v) > 1);
    endfunction

    // A vector is settled when the samples taken DB_CYCLES+... edges back
    // (window of DB+1 consecutive samples, ending 2 edges ago) all agree.
    always @(posedge clk) begin : model_p
        logic       settled;
        logic [N:0] w;
        if (rst) begin
            for (int i = 0; i < int'(HN); i++)
                hist[i] = (i < 3) ? 17'h00000 : 17'h10000;
            m_busy  = 1'b0;
            m_acc   = '0;
            m_led   = '0;
            m_valid = 1'b0;
            m_evt   = 1'b0;
            m_err   = 1'b0;
        end else begin
            w       = hist[2];
            settled = !w[N];
            for (int i = 3; i <= int'(DB) + 2; i++)
                if (hist[i] !== w) settled = 1'b0;
            if (!m_busy) begin
                if (settled && (w[N-1:0] !== m_acc)) begin
                    m_acc   = w[N-1:0];
                    m_led   = ref_msb(w[N-1:0]);
                    m_valid = (w[N-1:0] != '0);
                    m_err   = ref_err(w[N-1:0]);
                    m_evt   = 1'b1;
                    m_busy  = 1'b1;
                end
            end else if (ack) begin
                m_evt  = 1'b0;
                m_busy = 1'b0;
            end
            for (int i = int'(HN) - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {1'b0, SW};
        end
    end

    // Waits (bounded) for evt; result reported to the caller.
    task automatic wait_evt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (evt === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; SW = '0; ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({LED, valid, evt, err} !== {CW'(0), 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle c=%0d: LED=%0d valid=%b evt=%b err=%b, want all 0",
                         c, LED, valid, evt, err);
            end
        end
    endtask

    task automatic test_single();
        SW = 16'h0020;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (e == 7) begin
                checks++;
                if (evt !== 1'b0) begin
                    errors++;
                    $display("FAIL single_early: evt=%b after edge 7, want 0", evt);
                end
            end
        end
        checks++;
        if ({evt, LED, valid, err} !== {1'b1, CW'(5), 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_latency: evt=%b LED=%0d valid=%b err=%b, want 1 5 1 0",
                     evt, LED, valid, err);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (evt !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: evt=%b, want 0", evt);
        end
    endtask

    task automatic test_multihot();
        bit ok;
        SW = 16'h8001;
        wait_evt(30, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL multihot_timeout: evt=%b, want 1 within 30 cycles", evt);
        end
        checks++;
        if ({LED, valid, err} !== {CW'(15), 1'b1, ERR_ON}) begin
            errors++;
            $display("FAIL multihot_out: LED=%0d valid=%b err=%b, want 15 1 %b",
                     LED, valid, err, ERR_ON);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (evt !== 1'b0) begin
            errors++;
            $display("FAIL multihot_ack: evt=%b, want 0", evt);
        end
    endtask

    task automatic test_bounce();
        int  rises;
        logic pevt;
        rises = 0;
        pevt  = evt;
        for (int c = 0; c < 40; c++) begin
            SW = (c < 10 && ((c / 2) % 2) == 1) ? 16'h0000 : 16'h0004;
            @(negedge clk);
            if (evt === 1'b1 && pevt !== 1'b1) rises++;
            pevt = evt;
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL bounce_events: got %0d events, want 1", rises);
        end
        checks++;
        if (LED !== CW'(2)) begin
            errors++;
            $display("FAIL bounce_led: LED=%0d, want 2", LED);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_report_hold();
        bit ok;
        SW = 16'h0002;
        wait_evt(30, ok);
        checks++;
        if (!ok || LED !== CW'(1)) begin
            errors++;
            $display("FAIL hold_first: evt=%b LED=%0d, want 1 1", evt, LED);
        end
        SW = 16'h0100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({evt, LED} !== {1'b1, CW'(1)}) begin
                errors++;
                $display("FAIL hold_frozen c=%0d: evt=%b LED=%0d, want 1 1", c, evt, LED);
            end
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (evt !== 1'b0) begin
            errors++;
            $display("FAIL hold_ack: evt=%b, want 0", evt);
        end
        wait_evt(30, ok);
        checks++;
        if (!ok || {LED, valid} !== {CW'(8), 1'b1}) begin
            errors++;
            $display("FAIL hold_second: evt=%b LED=%0d valid=%b, want 1 8 1", evt, LED, valid);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({LED, valid, evt, err} !== {CW'(0), 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: LED=%0d valid=%b evt=%b err=%b, want all 0",
                     LED, valid, evt, err);
        end
    endtask

    task automatic test_random();
        int          cyc;
        int          hold;
        logic [N-1:0] v;
        cyc = 0;
        v   = SW;
        while (cyc < 3000) begin
            case ($urandom_range(0, 3))
                0:       v = '0;
                1:       v = N'(1) << $urandom_range(0, N - 1);
                2:       v = N'($urandom);
                default: ;
            endcase
            hold = int'($urandom_range(1, 12));
            for (int h = 0; h < hold; h++) begin
                SW  = v;
                ack = ($urandom_range(0, 3) == 0);
                rst = ($urandom_range(0, 199) == 0);
                @(negedge clk);
                cyc++;
                checks++;
                if ({LED, valid, evt, err} !== {m_led, m_valid, m_evt, m_err}) begin
                    errors++;
                    $display("FAIL random cyc=%0d: LED=%0d valid=%b evt=%b err=%b, want %0d %b %b %b",
                             cyc, LED, valid, evt, err, m_led, m_valid, m_evt, m_err);
                end
            end
        end
        rst = 1'b0;
        ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multihot();
        test_bounce();
        test_report_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
